push_btn_array: RTL and testbench

Multi-channel successor to the single push-button controller. Debounces Channels independent buttons, latches each press until software reads it, and exposes reads through the same 12-bit instruction bus (4-bit opcode, 8-bit immediate) as the other peripherals. Adds per-channel read/clear, read-all, level read and a press-enable mask. Sits on the controller's instruction bus beside the other I/O peripherals.

---
 rtl/push_btn_array.sv | 219 +++++++++++++++++++++
 tb/tb_push_btn_array.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/push_btn_array.sv
// push_btn_array
//   Multi-channel push-button peripheral on the 12-bit instruction bus.
//   Each channel is debounced independently; a debounced 0->1 edge on an
//   unmasked channel latches a press that stays set until software reads it.
//
//   Optional feature: define PUSH_BTN_ARRAY_COUNT_EN to add an 8-bit
//   saturating press counter per channel and the RPC (0x5) instruction.
//   Without it, press_count is tied to 0 and opcode 0x5 is invalid.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-low reset
//   inst[11:0]    in   [11:8] opcode, [7:0] immediate
//   inst_en       in   execute inst on this edge
//   buttons       in   raw button levels, 1 = pressed
//   button_status out  result of the last read instruction
//   error         out  1 while in the Error state
//   press_count   out  RPC result (0 when the counter feature is absent)

module push_btn_array #(
  parameter int Channels     = 4,
  parameter int DebounceWait = 50,
  parameter int DebounceSize = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         inst,
  input  logic                inst_en,
  input  logic [Channels-1:0] buttons,
  output logic [Channels-1:0] button_status,
  output logic                error,
  output logic [7:0]          press_count
);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_ERROR = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_RBS = 4'h1,
    OP_RAS = 4'h2,
    OP_LVL = 4'h3,
    OP_MSK = 4'h4,
    OP_RPC = 4'h5
  } opcode_e;

  localparam logic [DebounceSize-1:0] CNT_LAST = DebounceSize'(DebounceWait - 1);
  localparam logic [DebounceSize-1:0] CNT_ONE  = DebounceSize'(1);
  localparam logic [7:0]              CH_LIM   = 8'(Channels);

  state_e                  r_state;
  state_e                  w_state_next;

  logic [DebounceSize-1:0] r_cnt [Channels];
  logic [Channels-1:0]     r_deb;
  logic [Channels-1:0]     r_latched;
  logic [Channels-1:0]     r_mask;
  logic [Channels-1:0]     r_status;
  logic [7:0]              r_pc;

  logic [Channels-1:0]     w_flip;
  logic [Channels-1:0]     w_press;
  logic [Channels-1:0]     w_clear;
  logic [Channels-1:0]     w_status_d;
  logic                    w_status_we;
  logic                    w_mask_we;
  logic                    w_invalid;
  logic                    w_exec;
  logic [3:0]              w_op;
  logic [7:0]              w_ch;
  logic                    w_ch_ok;

`ifdef PUSH_BTN_ARRAY_COUNT_EN
  logic [7:0]              r_count [Channels];
  logic                    w_rpc;
  logic [7:0]              w_sel_count;
`endif

  assign w_op    = inst[11:8];
  assign w_ch    = inst[7:0];
  assign w_ch_ok = (w_ch < CH_LIM);
  assign w_exec  = inst_en && (r_state == ST_READY);

  // Flip happens on the DebounceWait-th consecutive differing sample; a
  // press is only a rising flip on an unmasked channel.
  always_comb begin
    w_flip = '0;
    for (int unsigned i = 0; i < Channels; i++) begin
      w_flip[i] = (buttons[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
    end
    w_press = w_flip & buttons & r_mask;
  end

  // Instruction decode and next-state logic
  always_comb begin
    w_state_next = r_state;
    w_status_we  = 1'b0;
    w_status_d   = '0;
    w_clear      = '0;
    w_mask_we    = 1'b0;
    w_invalid    = 1'b0;
`ifdef PUSH_BTN_ARRAY_COUNT_EN
    w_rpc        = 1'b0;
`endif
    if (w_exec) begin
      case (w_op)
        OP_NOP: ;
        OP_RBS: begin
          if (w_ch_ok) begin
            w_status_we = 1'b1;
            for (int unsigned i = 0; i < Channels; i++) begin
              if (w_ch == 8'(i)) begin
                w_status_d[i] = r_latched[i];
                w_clear[i]    = 1'b1;
              end
            end
          end else begin
            w_invalid = 1'b1;
          end
        end
        OP_RAS: begin
          w_status_we = 1'b1;
          w_status_d  = r_latched;
          w_clear     = '1;
        end
        OP_LVL: begin
          w_status_we = 1'b1;
          w_status_d  = r_deb;
        end
        OP_MSK: w_mask_we = 1'b1;
`ifdef PUSH_BTN_ARRAY_COUNT_EN
        OP_RPC: begin
          if (w_ch_ok) w_rpc = 1'b1;
          else         w_invalid = 1'b1;
        end
`endif
        default: w_invalid = 1'b1;
      endcase
    end
    if (w_invalid) begin
      w_state_next = ST_ERROR;
      w_status_we  = 1'b1;
      w_status_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_READY;
    else        r_state <= w_state_next;
  end

  // Debouncers run regardless of state
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_deb <= '0;
      for (int unsigned i = 0; i < Channels; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < Channels; i++) begin
        if (buttons[i] == r_deb[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
        if (w_flip[i]) r_deb[i] <= buttons[i];
      end
    end
  end

  // Set wins over a same-edge clear, so no press is lost to a read
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_latched <= '0;
      r_mask    <= '1;
      r_status  <= '0;
    end else begin
      if (r_state == ST_READY) r_latched <= (r_latched & ~w_clear) | w_press;
      if (w_mask_we)           r_mask    <= inst[Channels-1:0];
      if (w_status_we)         r_status  <= w_status_d;
    end
  end

`ifdef PUSH_BTN_ARRAY_COUNT_EN
  always_comb begin
    w_sel_count = '0;
    for (int unsigned i = 0; i < Channels; i++) begin
      if (w_ch == 8'(i)) w_sel_count = r_count[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pc <= '0;
      for (int unsigned i = 0; i < Channels; i++) r_count[i] <= '0;
    end else begin
      if (w_rpc) r_pc <= w_sel_count;
      if (r_state == ST_READY) begin
        for (int unsigned i = 0; i < Channels; i++) begin
          if (w_rpc && w_ch == 8'(i)) begin
            r_count[i] <= w_press[i] ? 8'd1 : 8'd0;
          end else if (w_press[i] && r_count[i] != 8'hFF) begin
            r_count[i] <= r_count[i] + 8'd1;
          end
        end
      end
    end
  end
`else
  always_comb r_pc = '0;
`endif

  always_comb begin
    button_status = r_status;
    error         = (r_state == ST_ERROR);
    press_count   = r_pc;
  end

endmodule

// File: tb/tb_push_btn_array.sv
module tb_push_btn_array;

  logic        clock;
  logic        reset;
  logic [11:0] inst;
  logic        inst_en;
  logic [3:0]  buttons;
  logic [3:0]  button_status;
  logic        error;
  logic [7:0]  press_count;

  typedef struct {
    string      name;
    logic [3:0] st;
    logic       er;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  push_btn_array #(
    .Channels    (4),
    .DebounceWait(50),
    .DebounceSize(6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .inst         (inst),
    .inst_en      (inst_en),
    .buttons      (buttons),
    .button_status(button_status),
    .error        (error),
    .press_count  (press_count)
  );

  initial clock = 1'b0;
  always #2 clock = ~clock;

  // Monitor: any edge that executes an instruction or a reset produces a result
  initial begin
    logic ev;
    exp_t e;
    forever begin
      @(posedge clock);
      ev = inst_en || !reset;
      #1;
      if (ev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_result status=%b error=%b press_count=%0d (no expectation queued)",
                   button_status, error, press_count);
        end else begin
          e = exp_q.pop_front();
          if (button_status !== e.st || error !== e.er || press_count !== e.pc) begin
            n_errors++;
            $display("FAIL %s status=%b exp=%b error=%b exp=%b press_count=%0d exp=%0d",
                     e.name, button_status, e.st, error, e.er, press_count, e.pc);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end on a falling edge
  task automatic expect_res(input string name, input logic [3:0] st, input logic er, input logic [7:0] pc);
    exp_t e;
    e.name = name; e.st = st; e.er = er; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string name);
    expect_res(name, 4'b0000, 1'b0, 8'd0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] imm, input string name,
                       input logic [3:0] st, input logic er, input logic [7:0] pc);
    expect_res(name, st, er, pc);
    inst    = {op, imm};
    inst_en = 1'b1;
    @(negedge clock);
    inst_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input int ch, input int hi, input int lo);
    buttons[ch] = 1'b1;
    idle(hi);
    buttons[ch] = 1'b0;
    idle(lo);
  endtask

  initial begin
    reset = 1'b1; inst = '0; inst_en = 1'b0; buttons = '0;
    @(negedge clock);

    do_reset("reset_state");
    issue(4'h1, 8'h00, "rbs0_idle", 4'b0000, 1'b0, 8'd0);
    issue(4'hB, 8'h00, "invalid_op", 4'b0000, 1'b1, 8'd0);
    issue(4'h0, 8'h00, "nop_in_error", 4'b0000, 1'b1, 8'd0);
    do_reset("reset_clears_error");

    // Long hold on ch2
    buttons[2] = 1'b1;
    idle(200);
    issue(4'h3, 8'h00, "lvl_hold", 4'b0100, 1'b0, 8'd0);
    issue(4'h1, 8'h02, "rbs2_first", 4'b0100, 1'b0, 8'd0);
    issue(4'h1, 8'h02, "rbs2_second", 4'b0000, 1'b0, 8'd0);
    buttons[2] = 1'b0;
    idle(60);
    issue(4'h3, 8'h00, "lvl_released", 4'b0000, 1'b0, 8'd0);

    // Glitches on ch1 and the 49/50 boundary
    for (int k = 0; k < 3; k++) press(1, 10, 10);
    issue(4'h2, 8'h00, "ras_glitch", 4'b0000, 1'b0, 8'd0);
    buttons[1] = 1'b1;
    idle(49);
    buttons[1] = 1'b0;
    issue(4'h2, 8'h00, "ras_49", 4'b0000, 1'b0, 8'd0);
    buttons[1] = 1'b1;
    idle(50);
    issue(4'h2, 8'h00, "ras_50", 4'b0010, 1'b0, 8'd0);
    buttons[1] = 1'b0;
    idle(60);

    // Read on the very edge debounced[3] rises
    buttons[3] = 1'b1;
    idle(49);
    issue(4'h1, 8'h03, "rbs3_on_edge", 4'b0000, 1'b0, 8'd0);
    issue(4'h1, 8'h03, "rbs3_next", 4'b1000, 1'b0, 8'd0);
    buttons[3] = 1'b0;
    idle(60);

    // Mask, then out-of-range channel
    issue(4'h4, 8'h0E, "msk_holds", 4'b1000, 1'b0, 8'd0);
    buttons[1:0] = 2'b11;
    idle(60);
    buttons[1:0] = 2'b00;
    idle(60);
    issue(4'h2, 8'h00, "ras_masked", 4'b0010, 1'b0, 8'd0);
    issue(4'h1, 8'h04, "rbs_bad_ch", 4'b0000, 1'b1, 8'd0);
    press(1, 60, 60);
    issue(4'h2, 8'h00, "ras_in_error", 4'b0000, 1'b1, 8'd0);
    issue(4'h3, 8'h00, "lvl_in_error", 4'b0000, 1'b1, 8'd0);
    do_reset("reset_from_error");
    press(0, 60, 60);
    issue(4'h2, 8'h00, "ras_mask_reset", 4'b0001, 1'b0, 8'd0);

`ifdef PUSH_BTN_ARRAY_COUNT_EN
    issue(4'h5, 8'h00, "rpc0_one", 4'b0001, 1'b0, 8'd1);
    for (int k = 0; k < 3; k++) press(0, 60, 60);
    issue(4'h5, 8'h00, "rpc0_three", 4'b0001, 1'b0, 8'd3);
    issue(4'h5, 8'h00, "rpc0_cleared", 4'b0001, 1'b0, 8'd0);
    for (int k = 0; k < 300; k++) press(0, 52, 52);
    issue(4'h5, 8'h00, "rpc0_saturate", 4'b0001, 1'b0, 8'd255);
    issue(4'h5, 8'h04, "rpc_bad_ch", 4'b0000, 1'b1, 8'd255);
`else
    issue(4'h5, 8'h00, "rpc_absent", 4'b0000, 1'b1, 8'd0);
`endif

    idle(3);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover_expectations pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
